// File: rtl/pc_stack.sv
// pc_stack: WIDTH-bit program counter with a DEPTH-entry return-address stack.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   clr    - asynchronous active-high reset (pc, occupancy and err cleared)
//   bus    - shared tri-state system bus (driven with pc, or sampled)
//   ep     - drive pc onto the bus
//   lp     - jump: pc <= bus
//   cp     - pc <= pc + 1 (wraps)
//   call   - push pc, then pc <= bus
//   ret    - pop top of stack into pc
//   full   - occupancy == DEPTH
//   empty  - occupancy == 0
//   err    - sticky overflow/underflow flag
//   level  - current stack occupancy
//
// Command priority: call > ret > lp > cp > hold.
module pc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             ep,
    input  logic             lp,
    input  logic             cp,
    input  logic             call,
    input  logic             ret,
    output logic             full,
    output logic             empty,
    output logic             err,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [LW-1:0]    lvl;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             is_full;
    logic             is_empty;
    logic             do_push;

    assign is_full  = (lvl == LW'(DEPTH));
    assign is_empty = (lvl == '0);

    // Pointers are only used when the matching push/pop is legal, so the
    // truncation at level == DEPTH (push) or level == 0 (pop) never matters.
    assign wptr = lvl[AW-1:0];
    assign rptr = AW'(lvl - LW'(1));

    assign do_push = call && !is_full;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc  <= '0;
            lvl <= '0;
            err <= 1'b0;
        end else if (call) begin
            // ret in the same cycle is ignored entirely, including its error
            if (is_full) begin
                err <= 1'b1;
            end else begin
                pc  <= bus;
                lvl <= lvl + LW'(1);
            end
        end else if (ret) begin
            if (is_empty) begin
                err <= 1'b1;
            end else begin
                pc  <= stack[rptr];
                lvl <= lvl - LW'(1);
            end
        end else if (lp) begin
            pc <= bus;
        end else if (cp) begin
            pc <= pc + WIDTH'(1);
        end
    end

    // Stack storage is never reset; entries above the occupancy are unobservable.
    // The clr term keeps a reset landing on a call edge from leaving a partial push.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            stack[wptr] <= pc;
        end
    end

    // Never drive in a cycle where the bus is being sampled.
    assign bus = (ep && !lp && !call) ? pc : {WIDTH{1'bz}};

    assign full  = is_full;
    assign empty = is_empty;
    assign level = lvl;

endmodule

// File: tb/tb_pc_stack.sv
// Directed testbench for pc_stack (WIDTH=8, DEPTH=4).
// pc is observed through the bus by asserting ep with no other command.
module tb_pc_stack;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ep = 1'b0, lp = 1'b0, cp = 1'b0, call = 1'b0, ret = 1'b0;
    logic       oe = 1'b0;
    logic [7:0] drv = 8'h00;
    wire  [7:0] bus;
    logic       full, empty, err;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;

    assign bus = oe ? drv : 8'hzz;

    pc_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .clr(clr), .bus(bus), .ep(ep), .lp(lp), .cp(cp),
        .call(call), .ret(ret), .full(full), .empty(empty), .err(err),
        .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       lp, cp, call, ret;
        logic [7:0] bv;
        logic [7:0] epc;
        logic [2:0] elv;
        logic       eful, eemp, eerr;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // bus must be released: high-Z on a 4-state simulator, 0 on a 2-state one
    task automatic chk_rel(input string nm);
        total++;
        if (!(bus === 8'hzz || bus === 8'h00)) begin
            bad++;
            $display("FAIL %s: bus %0h expected released", nm, bus);
        end
    endtask

    task automatic observe(input string nm, input logic [7:0] epc, input logic [2:0] elv,
                           input logic ef, input logic ee, input logic er);
        chk({nm, ".pc"},    32'(bus),   32'(epc));
        chk({nm, ".level"}, 32'(level), 32'(elv));
        chk({nm, ".full"},  32'(full),  32'(ef));
        chk({nm, ".empty"}, 32'(empty), 32'(ee));
        chk({nm, ".err"},   32'(err),   32'(er));
    endtask

    // Apply one command for one rising edge, then park in observe mode (ep only).
    task automatic cyc(input logic l, input logic c, input logic ca, input logic r,
                       input logic [7:0] v);
        @(negedge clk);
        ep = 1'b0; lp = l; cp = c; call = ca; ret = r; drv = v; oe = l | ca;
        @(posedge clk);
        #1;
        lp = 1'b0; cp = 1'b0; call = 1'b0; ret = 1'b0; oe = 1'b0; ep = 1'b1;
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic l, input logic c, input logic ca,
                                input logic r, input logic [7:0] bv, input logic [7:0] epc,
                                input logic [2:0] elv, input logic ef, input logic ee,
                                input logic er);
        vec_t t;
        t.nm = nm; t.lp = l; t.cp = c; t.call = ca; t.ret = r; t.bv = bv;
        t.epc = epc; t.elv = elv; t.eful = ef; t.eemp = ee; t.eerr = er;
        return t;
    endfunction

    initial begin
        //            name     lp cp ca rt bus    pc    lvl fu em er
        vt[0]  = mk("ld_fe",  1, 0, 0, 0, 8'hFE, 8'hFE, 0, 0, 1, 0);
        vt[1]  = mk("inc1",   0, 1, 0, 0, 8'h00, 8'hFF, 0, 0, 1, 0);
        vt[2]  = mk("inc2",   0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
        vt[3]  = mk("inc3",   0, 1, 0, 0, 8'h00, 8'h01, 0, 0, 1, 0);
        vt[4]  = mk("ld_10",  1, 0, 0, 0, 8'h10, 8'h10, 0, 0, 1, 0);
        vt[5]  = mk("call40", 0, 0, 1, 0, 8'h40, 8'h40, 1, 0, 0, 0);
        vt[6]  = mk("inc41",  0, 1, 0, 0, 8'h00, 8'h41, 1, 0, 0, 0);
        vt[7]  = mk("call80", 0, 0, 1, 0, 8'h80, 8'h80, 2, 0, 0, 0);
        vt[8]  = mk("ret41",  0, 0, 0, 1, 8'h00, 8'h41, 1, 0, 0, 0);
        vt[9]  = mk("ret10",  0, 0, 0, 1, 8'h00, 8'h10, 0, 0, 1, 0);
        vt[10] = mk("call1",  0, 0, 1, 0, 8'h01, 8'h01, 1, 0, 0, 0);
        vt[11] = mk("call2",  0, 0, 1, 0, 8'h02, 8'h02, 2, 0, 0, 0);
        vt[12] = mk("call3",  0, 0, 1, 0, 8'h03, 8'h03, 3, 0, 0, 0);
        vt[13] = mk("call4",  0, 0, 1, 0, 8'h04, 8'h04, 4, 1, 0, 0);
        vt[14] = mk("ovf",    0, 0, 1, 0, 8'h55, 8'h04, 4, 1, 0, 1);
        vt[15] = mk("pop3",   0, 0, 0, 1, 8'h00, 8'h03, 3, 0, 0, 1);
        vt[16] = mk("pop2",   0, 0, 0, 1, 8'h00, 8'h02, 2, 0, 0, 1);
        vt[17] = mk("pop1",   0, 0, 0, 1, 8'h00, 8'h01, 1, 0, 0, 1);
        vt[18] = mk("pop10",  0, 0, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1);
        vt[19] = mk("unf",    0, 0, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1);

        // Reset released between edges
        #12 clr = 1'b0;
        #1;
        chk_rel("rst_bus_z");
        ep = 1'b1;
        #1;
        observe("rst", 8'h00, 0, 0, 1, 0);

        foreach (vt[i]) begin
            cyc(vt[i].lp, vt[i].cp, vt[i].call, vt[i].ret, vt[i].bv);
            observe(vt[i].nm, vt[i].epc, vt[i].elv, vt[i].eful, vt[i].eemp, vt[i].eerr);
        end

        // Underflow straight from reset
        #3 clr = 1'b1;
        #2 clr = 1'b0;
        #1 observe("rst2", 8'h00, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 8'h00);
        observe("unf_rst", 8'h00, 0, 0, 1, 1);

        // Priority checks, from a clean reset
        @(negedge clk); clr = 1'b1; #2 clr = 1'b0; #1;
        cyc(1, 1, 0, 0, 8'h20);
        observe("lp_over_cp", 8'h20, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 8'h30);
        observe("call_over_ret", 8'h30, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 8'h77);
        observe("ret_over_lp", 8'h20, 0, 0, 1, 0);
        // call full with ret high: overflow flagged, nothing popped
        cyc(0, 0, 1, 0, 8'hA1);
        cyc(0, 0, 1, 0, 8'hA2);
        cyc(0, 0, 1, 0, 8'hA3);
        cyc(0, 0, 1, 0, 8'hA4);
        cyc(0, 0, 1, 1, 8'hA5);
        observe("full_call_ret", 8'hA4, 4, 1, 0, 1);

        // Reset landing on a call edge with level=3 (err already set)
        cyc(0, 0, 0, 1, 8'h00);
        observe("pre_rst", 8'hA3, 3, 0, 0, 1);
        @(negedge clk);
        ep = 1'b0; call = 1'b1; oe = 1'b1; drv = 8'h99;
        #2 clr = 1'b1;
        @(posedge clk);
        #2 clr = 1'b0; call = 1'b0; oe = 1'b0; ep = 1'b1;
        #1 observe("rst_in_call", 8'h00, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 8'h00);
        observe("no_partial_push", 8'h00, 0, 0, 1, 1);

        // Bus contention: pc = A5, block must release whenever lp or call is high
        cyc(1, 0, 0, 0, 8'hA5);
        chk("bus_ep", 32'(bus), 32'hA5);
        ep = 1'b0; #1;
        chk_rel("bus_ep0");
        @(negedge clk);
        ep = 1'b1; lp = 1'b1; oe = 1'b1; drv = 8'h3C; #1;
        chk("bus_lp_ep", 32'(bus), 32'h3C);
        lp = 1'b0; call = 1'b1; drv = 8'h5A; #1;
        chk("bus_call_ep", 32'(bus), 32'h5A);
        call = 1'b0; oe = 1'b0; #1;
        chk("bus_ep_after", 32'(bus), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised successor to the program counter and the single-register subroutine counter. It combines a WIDTH-bit program counter with a DEPTH-entry hardware return-address stack, so subroutine calls can nest. It shares the tri-state system bus with the rest of the datapath and is driven by the control unit's strobe lines. It also reports stack occupancy and full/empty status, and raises a sticky error on stack overflow or underflow.

## Interface
Parameters:
- WIDTH, 8, bit width of the program counter, the bus and each stack entry
- DEPTH, 4, number of return-address entries; must be ≥ 2

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- clr  in  1  reset, asynchronous, active-high; clears all state
- bus  inout  WIDTH  shared system bus
- ep  in  1  drive the PC onto the bus
- lp  in  1  jump: load PC from the bus
- cp  in  1  increment PC
- call  in  1  push the PC, then load PC from the bus
- ret  in  1  pop the top of stack into the PC
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- err  out  1  sticky overflow/underflow flag
- level  out  $clog2(DEPTH+1)  current stack occupancy

## Operation
- State:
  - pc register (WIDTH)
  - stack array of DEPTH × WIDTH
  - stack pointer / occupancy counter `level`
  - err flag
- Command priority each cycle: call > ret > lp > cp > hold. Only the highest-priority asserted command takes effect.
- **call**, not full:
  - stack[level] <= pc; level <= level+1; pc <= bus.
  - The pushed value is the PC as it stands. The control unit has already incremented it past the call instruction.
- **call**, full:
  - No push; pc and level unchanged; err <= 1.
- **ret**, not empty:
  - pc <= stack[level-1]; level <= level-1.
- **ret**, empty:
  - pc and level unchanged; err <= 1.
- **lp**: pc <= bus. Stack untouched.
- **cp**: pc <= pc+1, modulo 2^WIDTH (all-ones wraps to 0). No flag.
- err is sticky and clears only on clr.
- Bus drive:
  - bus = pc when ep=1 and lp=0 and call=0; otherwise high-Z.
  - The block never drives the bus in a cycle where it samples it.
- Flags: full, empty and level are decoded from the registered occupancy. There is no combinational path from command inputs to them.
- Stack entries above `level` are don't-care and are never observable.

## Timing
- Reset (clr high, asynchronous, independent of clk):
  - pc=0, level=0, empty=1, full=0, err=0.
  - Stack contents are not cleared.
  - State holds while clr is high. The first command is taken on the first rising clk edge after clr falls.
- Reset asserted mid-operation (e.g. in the same cycle as a call) overrides everything. Post-reset state as above, with no partial push.
- Latency:
  - Every command is single-cycle: the new pc, level and flags are visible after the rising edge that samples the command.
  - Back-to-back call/call, call/ret and ret/ret work every cycle with no bubble.
- ret directly after call returns the value pushed on the previous edge. The stack write and read are not bypassed; they are simply sequential.
- Bus output is combinational from the pc register and ep/lp/call. It updates in the same cycle pc changes.
- With call and ret both high, ret is ignored and does not set err. The full/overflow check applies to the call.

## Test plan
- **Reset/idle.** Pulse clr between clock edges.
  - Expect pc=0, empty=1, level=0, err=0, bus high-Z.
  - With ep=1, expect bus=8'h00.
- **Increment wrap.** lp with bus=8'hFE, then cp for 3 cycles.
  - Expect pc 8'hFF, 8'h00, 8'h01. err stays 0.
- **Nested call/return** (DEPTH=4).
  - pc=8'h10, call with bus=8'h40 → pc=8'h40, level=1.
  - cp → 8'h41; call with bus=8'h80 → pc=8'h80, level=2.
  - ret → pc=8'h41, level=1; ret → pc=8'h10, empty=1.
- **Overflow.**
  - Four calls (targets 1, 2, 3, 4) → full=1, level=4.
  - Fifth call with bus=8'h55 → pc stays 8'h04, level=4, err=1.
  - Four rets → pc sequence 3, 2, 1, original. err stays 1.
- **Underflow and priority.**
  - From reset, ret → pc=0, err=1.
  - lp and cp together with bus=8'h20 → pc=8'h20.
  - call and ret together with bus=8'h30 → push, pc=8'h30, level=1.
- **Reset mid-stack and bus contention.**
  - With level=3, assert clr during a call cycle → level=0, pc=0, err=0.
  - Check bus is high-Z whenever lp or call is high, even if ep=1.
